// File: rtl/wordle_pkg.sv
// Shared types for the Wordle guess scorer: letter colour codes and the
// one-hot controller state encoding.
package wordle_pkg;

  typedef enum logic [1:0] {
    GRAY   = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } colour_t;

  typedef enum logic [5:0] {
    QI = 6'b000001,
    QW = 6'b000010,
    QG = 6'b000100,
    QY = 6'b001000,
    QR = 6'b010000,
    QD = 6'b100000
  } state_t;

  // Index register width; a 1-letter word still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wordle_guess_scorer_if.sv
// Guess submission / result reporting bundle between letter entry, the
// scorer and the renderer.
interface wordle_guess_scorer_if #(
  parameter int unsigned WORD_LEN    = 5,
  parameter int unsigned LETTER_W    = 8,
  parameter int unsigned MAX_GUESSES = 6
);
  localparam int unsigned CNT_W = $clog2(MAX_GUESSES + 1);

  logic                         guess_valid;
  logic [WORD_LEN*LETTER_W-1:0] guess_word;
  logic                         ready;
  logic                         result_valid;
  logic [2*WORD_LEN-1:0]        result;
  logic [CNT_W-1:0]             guess_count;
  logic                         win;
  logic                         lose;

  modport master (
    output guess_valid, guess_word,
    input  ready, result_valid, result, guess_count, win, lose
  );

  modport slave (
    input  guess_valid, guess_word,
    output ready, result_valid, result, guess_count, win, lose
  );
endinterface

// File: rtl/wordle_letter_match.sv
// Finds the lowest-index secret position holding a given letter that has
// not yet been credited to another guess letter.
module wordle_letter_match #(
  parameter int unsigned WORD_LEN = 5,
  parameter int unsigned LETTER_W = 8
) (
  input  logic [LETTER_W-1:0]               letter,
  input  logic [WORD_LEN-1:0][LETTER_W-1:0] secret,
  input  logic [WORD_LEN-1:0]               used,
  output logic                              found,
  output logic [WORD_LEN-1:0]               match_pos
);

  always_comb begin
    found     = 1'b0;
    match_pos = '0;
    for (int unsigned j = 0; j < WORD_LEN; j++) begin
      if (!found && !used[j] && secret[j] == letter) begin
        found        = 1'b1;
        match_pos[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wordle_guess_scorer.sv
// Wordle game engine: latches a secret, scores guesses one letter per cycle
// (green pass then yellow pass) and tracks guess count and win/lose.
module wordle_guess_scorer
  import wordle_pkg::*;
#(
  parameter int unsigned WORD_LEN    = 5,
  parameter int unsigned LETTER_W    = 8,
  parameter int unsigned MAX_GUESSES = 6
) (
  input  logic                         Clk,
  input  logic                         reset,
  input  logic                         Start,
  input  logic                         Ack,
  input  logic [WORD_LEN*LETTER_W-1:0] secret_word,
  wordle_guess_scorer_if.slave         bus,
  output logic                         q_I,
  output logic                         q_W,
  output logic                         q_G,
  output logic                         q_Y,
  output logic                         q_R,
  output logic                         q_D
);

  localparam int unsigned CNT_W = $clog2(MAX_GUESSES + 1);
  localparam int unsigned IDX_W = idx_width(WORD_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_LEN - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_GUESSES);

  state_t                            state;
  logic [WORD_LEN-1:0][LETTER_W-1:0] secret_q;
  logic [WORD_LEN-1:0][LETTER_W-1:0] guess_q;
  logic [WORD_LEN-1:0]               green;
  logic [WORD_LEN-1:0]               yellow;
  logic [WORD_LEN-1:0]               used;
  logic [IDX_W-1:0]                  idx;
  logic [2*WORD_LEN-1:0]             result_q;
  logic [CNT_W-1:0]                  count_q;
  logic                              win_q;
  logic                              lose_q;
  logic                              result_valid_q;

  logic [LETTER_W-1:0]   cur_guess;
  logic [LETTER_W-1:0]   cur_secret;
  logic [WORD_LEN-1:0]   idx_onehot;
  logic                  found;
  logic [WORD_LEN-1:0]   match_pos;
  logic                  yellow_hit;
  logic [WORD_LEN-1:0]   yellow_next;
  logic [2*WORD_LEN-1:0] colour_vec;
  logic                  all_green;
  logic [CNT_W-1:0]      count_inc;

  assign cur_guess  = guess_q[idx];
  assign cur_secret = secret_q[idx];

  wordle_letter_match #(
    .WORD_LEN (WORD_LEN),
    .LETTER_W (LETTER_W)
  ) u_match (
    .letter    (cur_guess),
    .secret    (secret_q),
    .used      (used),
    .found     (found),
    .match_pos (match_pos)
  );

  always_comb begin
    idx_onehot = '0;
    for (int unsigned j = 0; j < WORD_LEN; j++) begin
      idx_onehot[j] = (idx == IDX_W'(j));
    end
  end

  // The last letter's yellow decision lands on the same edge that builds the
  // report, so the colour vector is formed from the next-state yellow mask.
  assign yellow_hit  = ~|(green & idx_onehot) && found;
  assign yellow_next = yellow | (yellow_hit ? idx_onehot : '0);
  assign all_green   = &green;
  assign count_inc   = count_q + 1'b1;

  always_comb begin
    colour_vec = '0;
    for (int unsigned j = 0; j < WORD_LEN; j++) begin
      colour_vec[2*j +: 2] = green[j] ? GREEN : (yellow_next[j] ? YELLOW : GRAY);
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state          <= QI;
      secret_q       <= '0;
      guess_q        <= '0;
      green          <= '0;
      yellow         <= '0;
      used           <= '0;
      idx            <= '0;
      result_q       <= '0;
      count_q        <= '0;
      win_q          <= 1'b0;
      lose_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (state)
        QI: begin
          if (Start) begin
            secret_q <= secret_word;
            count_q  <= '0;
            win_q    <= 1'b0;
            lose_q   <= 1'b0;
            result_q <= '0;
            state    <= QW;
          end
        end
        QW: begin
          if (bus.guess_valid) begin
            guess_q <= bus.guess_word;
            green   <= '0;
            yellow  <= '0;
            used    <= '0;
            idx     <= '0;
            state   <= QG;
          end
        end
        QG: begin
          if (cur_guess == cur_secret) begin
            green <= green | idx_onehot;
            used  <= used | idx_onehot;
          end
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= QY;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        QY: begin
          yellow <= yellow_next;
          if (yellow_hit) begin
            used <= used | match_pos;
          end
          if (idx == LAST_IDX) begin
            result_q       <= colour_vec;
            count_q        <= count_inc;
            win_q          <= all_green;
            lose_q         <= !all_green && (count_inc == MAX_CNT);
            result_valid_q <= 1'b1;
            state          <= QR;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        QR: begin
          state <= (win_q || lose_q) ? QD : QW;
        end
        QD: begin
          if (Ack) begin
            state <= QI;
          end
        end
        default: state <= QI;
      endcase
    end
  end

  assign bus.ready        = (state == QW);
  assign bus.result_valid = result_valid_q;
  assign bus.result       = result_q;
  assign bus.guess_count  = count_q;
  assign bus.win          = win_q;
  assign bus.lose         = lose_q;

  assign q_I = (state == QI);
  assign q_W = (state == QW);
  assign q_G = (state == QG);
  assign q_Y = (state == QY);
  assign q_R = (state == QR);
  assign q_D = (state == QD);

endmodule

// File: doc/wordle_guess_scorer.md
Name: wordle_guess_scorer

Overview:
Parametrised Wordle game engine that replaces the fixed 5-letter, 6-guess flow with configurable word length, letter width and guess limit. It latches a secret word on Start and accepts guesses through a ready/valid handshake. Each guess is scored sequentially with correct duplicate-letter handling (green pass, then yellow pass), and the block reports a per-letter colour vector, the guess count and win/lose status. It sits between the keyboard/letter-entry logic and the VGA renderer, and runs on the same system clock as the game state machine.

Parameters:
WORD_LEN, 5, letters per word (≥1).
LETTER_W, 8, bits per letter code (ASCII by default).
MAX_GUESSES, 6, guesses allowed before loss (≥1).
CNT_W, $clog2(MAX_GUESSES+1), localparam: guess counter width.

Ports:
Clk  input  1  system clock, all logic on rising edge.
reset  input  1  asynchronous, active-high; clears all state.
Start  input  1  single-cycle pulse; latches secret_word, begins game (honoured in QI only).
Ack  input  1  single-cycle pulse; leaves QD for QI (honoured in QD only).
secret_word  input  WORD_LEN*LETTER_W  target word; letter i = [LETTER_W*i +: LETTER_W].
guess_valid  input  1  guess offered; accepted only while ready=1.
guess_word  input  WORD_LEN*LETTER_W  guess; same letter packing as secret_word.
ready  output  1  high exactly in state QW.
result_valid  output  1  one-cycle pulse in QR.
result  output  2*WORD_LEN  letter i at [2i+1:2i]: 00 gray, 01 yellow, 10 green.
guess_count  output  CNT_W  guesses scored this game.
win  output  1  last guess was all green.
lose  output  1  MAX_GUESSES scored without a win.
q_I, q_W, q_G, q_Y, q_R, q_D  output  1 each  one-hot state flags (Idle, Wait, Green pass, Yellow pass, Report, Done).

Behaviour:
- Reset: state QI; ready=0, result_valid=0, result=0, guess_count=0, win=0, lose=0, and internal secret/guess/used/index registers cleared. Reset mid-scoring aborts with no partial result.
- QI: on Start, latch secret_word, clear guess_count/win/lose/result, then go to QW. guess_valid is ignored in QI.
- QW: ready=1. On guess_valid, latch guess_word, clear the green/used flags, set idx=0, then go to QG. Start is ignored in QW.
- QG, one letter per cycle for idx=0..WORD_LEN-1: if guess[idx]==secret[idx], set green[idx] and used[idx]. After idx=WORD_LEN-1, set idx=0 and go to QY.
- QY, one letter per cycle: if green[idx]=0, find the lowest j with used[j]=0 and secret[j]==guess[idx]. If found, set yellow[idx] and used[j]. An unmatched letter stays gray. After the last letter, go to QR.
- Latency: guess sampled at edge t gives cycles t+1..t+W in QG, t+W+1..t+2W in QY, and QR at cycle t+2W+1 (11 cycles for W=5). Back-pressure: ready=0 throughout scoring.
- Entry to QR, all registered:
  - result ← colour vector.
  - guess_count +1.
  - win ← all green.
  - lose ← !all_green && guess_count+1==MAX_GUESSES.
- In QR, result_valid=1 for one cycle. Next state is QD if win or lose, else QW.
- QD: outputs hold. On Ack, go to QI; result, guess_count, win and lose hold until the next Start.
- result holds its value between reports. Duplicate letters:
  - each secret position is credited at most once;
  - green takes priority over yellow;
  - yellow goes to the lowest-index unused secret position.
- Letter codes are compared for equality only; there is no dictionary or range check.
- guess_count never exceeds MAX_GUESSES and does not wrap.
- Start/Ack outside their states and guess_valid outside QW have no effect.

Decomposition:
- Package wordle_pkg: result codes (GRAY=2'b00, YELLOW=2'b01, GREEN=2'b10) and the one-hot state encodings.
- Sub-module wordle_letter_match (combinational): inputs are a letter, the secret vector and the used mask. Outputs are found and a one-hot match_pos for the lowest matching unused position. It is instantiated once for the QY pass.

Test Plan:
1. Secret "ABBEY", guess "BABES" (W=5, ASCII) -> result=10'h0A5 (Y,Y,G,G,gray), guess_count=1, win=0; next state QW.
2. Secret "CRANE", guess "EERIE" -> result=10'h210 (only the last E green, R yellow, other E's gray); checks the used-mask handling of duplicates.
3. Guess equal to the secret on the 3rd guess -> result=10'h2AA, win=1, guess_count=3, QD entered; Ack -> QI with win still 1.
4. Six non-matching guesses (MAX_GUESSES=6) -> lose=1 after the 6th report, guess_count=6, then QD. A further guess_valid is ignored, ready=0.
5. Timing: guess_valid at edge t -> result_valid high only in cycle t+11; ready=0 during t+1..t+11. Start during QW and guess_valid in QI cause no state change.
6. reset asserted mid-QY -> all outputs cleared immediately, state QI; rerun with W=4, MAX_GUESSES=3 to confirm parametrisation.
